// File: rtl/cic_decimator_if.sv
// Sample stream interface of the CIC decimator: input samples with rate request,
// decimated output samples with a single-cycle valid.
interface cic_decimator_if #(
  parameter int WIDTH         = 8,
  parameter int MAX_RATE_LOG2 = 4
);
  logic [WIDTH-1:0]                     in;
  logic                                 in_valid;
  logic [$clog2(MAX_RATE_LOG2+1)-1:0]   rate_log2;
  logic [WIDTH-1:0]                     out;
  logic                                 out_valid;

  modport master (output in, in_valid, rate_log2, input out, out_valid);
  modport slave  (input in, in_valid, rate_log2, output out, out_valid);
endinterface

// File: rtl/cic_decimator.sv
// CIC decimator with runtime rate 2^rate_log2 and gain-normalised output.
// Optional macro CIC_DECIMATOR_ROUND_EN: round-half-up and saturate on normalisation.
module cic_decimator #(
  parameter int WIDTH         = 8,
  parameter int STAGES        = 3,
  parameter int MAX_RATE_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rstn,
  cic_decimator_if.slave  bus
);
  localparam int RW  = WIDTH + STAGES * MAX_RATE_LOG2;
  localparam int RLW = $clog2(MAX_RATE_LOG2 + 1);
  localparam int PW  = MAX_RATE_LOG2;
  localparam int SW  = $clog2(RW + 1);

  logic [RW-1:0]    integ    [STAGES];
  logic [RW-1:0]    comb_dly [STAGES];
  logic [RW-1:0]    comb_in  [STAGES];
  logic [RW-1:0]    comb_out;
  logic [PW-1:0]    phase;
  logic [PW-1:0]    phase_last;
  logic [RLW-1:0]   rate;
  logic [RLW-1:0]   rate_req;
  logic [RLW-1:0]   rate_cur;
  logic [SW-1:0]    shift_amt;
  logic [WIDTH-1:0] norm;
  logic             frame_stb;
  logic             done;

  always_comb begin
    if (bus.rate_log2 == '0)
      rate_req = RLW'(1);
    else if (bus.rate_log2 > RLW'(MAX_RATE_LOG2))
      rate_req = RLW'(MAX_RATE_LOG2);
    else
      rate_req = bus.rate_log2;
  end

  // The rate is captured on a frame's first sample, so phase 0 uses the live request.
  assign rate_cur   = (phase == '0) ? rate_req : rate;
  assign phase_last = ~({PW{1'b1}} << rate_cur);
  assign done       = bus.in_valid && (phase == phase_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (bus.in_valid) begin
      integ[0] <= integ[0] + RW'(bus.in);
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase     <= '0;
      rate      <= RLW'(1);
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= done;
      if (bus.in_valid) begin
        if (phase == '0) rate <= rate_req;
        phase <= done ? '0 : phase + PW'(1);
      end
    end
  end

  always_comb begin
    logic [RW-1:0] acc;
    acc = integ[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      comb_in[k] = acc;
      acc        = acc - comb_dly[k];
    end
    comb_out = acc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) comb_dly[k] <= '0;
    end else if (frame_stb) begin
      for (int k = 0; k < STAGES; k++) comb_dly[k] <= comb_in[k];
    end
  end

  // Still the frame's own rate: a new frame only relatches at the end of this cycle.
  assign shift_amt = SW'(STAGES * int'(rate));

`ifdef CIC_DECIMATOR_ROUND_EN
  localparam logic [RW:0] ROUND_ONE = (RW+1)'(1);
  logic [RW:0] rounded;
  logic [RW:0] shifted;

  always_comb begin
    rounded = {1'b0, comb_out} + (ROUND_ONE << (shift_amt - SW'(1)));
    shifted = rounded >> shift_amt;
    if (|shifted[RW:WIDTH])
      norm = '1;
    else
      norm = shifted[WIDTH-1:0];
  end
`else
  assign norm = WIDTH'(comb_out >> shift_amt);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= frame_stb;
      if (frame_stb) bus.out <= norm;
    end
  end
endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: directed scenarios plus random traffic,
// all compared each cycle against a frame-level arithmetic model.
module tb_cic_decimator;
  localparam int W   = 8;
  localparam int S   = 3;
  localparam int M   = 4;
  localparam int RW  = W + S * M;
  localparam longint MASK = (longint'(1) << RW) - 1;
`ifdef CIC_DECIMATOR_ROUND_EN
  localparam int ROUND_EXP = 1;
`else
  localparam int ROUND_EXP = 0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  cic_decimator_if #(.WIDTH(W), .MAX_RATE_LOG2(M)) bus ();
  cic_decimator #(.WIDTH(W), .STAGES(S), .MAX_RATE_LOG2(M)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; } exp_t;
  exp_t   expq[$];
  longint integ_m[S];
  longint hist[$];
  int     phase_m, rate_m, ec;
  int     acc_count, first_acc_edge;

  function automatic longint binom(int n, int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int normalise(longint v, int sh);
`ifdef CIC_DECIMATOR_ROUND_EN
    longint t = (v + (longint'(1) << (sh - 1))) >> sh;
    if (t > (1 << W) - 1) t = (1 << W) - 1;
    return int'(t);
`else
    return int'((v >> sh) & ((1 << W) - 1));
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) integ_m[k] = 0;
    hist.delete();
    phase_m = 0;
    rate_m  = 1;
  endtask

  // One accepted sample: cascaded running sums, and at frame end an S-th order
  // difference of the decimated sequence followed by division by R^S.
  task automatic model_accept(int x, int rl);
    longint v;
    if (phase_m == 0) rate_m = (rl == 0) ? 1 : ((rl > M) ? M : rl);
    for (int k = S - 1; k >= 1; k--) integ_m[k] = (integ_m[k] + integ_m[k-1]) & MASK;
    integ_m[0] = (integ_m[0] + x) & MASK;
    acc_count++;
    if (acc_count == 1) first_acc_edge = ec;
    phase_m++;
    if (phase_m == (1 << rate_m)) begin
      phase_m = 0;
      hist.push_back(integ_m[S-1]);
      if (hist.size() > S + 1) void'(hist.pop_front());
      v = 0;
      for (int k = 0; k <= S; k++)
        if (hist.size() > k)
          v += ((k % 2) ? -1 : 1) * binom(S, k) * hist[hist.size() - 1 - k];
      v = v & MASK;
      expq.push_back('{ec + 1, normalise(v, S * rate_m)});
    end
  endtask

  initial begin
    ec = 0;
    acc_count = 0;
    model_reset();
    forever begin
      @(posedge clk);
      ec++;
      if (!rstn) model_reset();
      else if (bus.in_valid) model_accept(int'(bus.in), int'(bus.rate_log2));
    end
  end

  // ---------------- compare process ----------------
  int last_out = 0;
  int pulse_cnt, first_pulse, prev_pulse, last_pulse, dut_last;

  task automatic clear_stats();
    pulse_cnt = 0; first_pulse = -1; prev_pulse = -1; last_pulse = -1;
    acc_count = 0; first_acc_edge = -1;
  endtask

  initial begin
    clear_stats();
    dut_last = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        expq.delete();
        last_out = 0;
        check("reset_out_valid", longint'(bus.out_valid), 0);
        check("reset_out", longint'(bus.out), 0);
      end else begin
        bit exp_v;
        exp_v = (expq.size() > 0) && (expq[0].due == ec);
        if (exp_v) begin
          last_out = expq[0].val;
          void'(expq.pop_front());
        end
        check("out_valid", longint'(bus.out_valid), longint'(exp_v));
        check("out", longint'(bus.out), longint'(last_out));
        if (bus.out_valid) begin
          pulse_cnt++;
          if (pulse_cnt == 1) first_pulse = ec;
          prev_pulse = last_pulse;
          last_pulse = ec;
          dut_last   = int'(bus.out);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int x, bit v, int rl);
    @(posedge clk);
    #1;
    bus.in        = W'(x);
    bus.in_valid  = v;
    bus.rate_log2 = 3'(rl);
  endtask

  task automatic reset_for(int n);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_stats();
  endtask

  initial begin
    int rl;
    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.rate_log2 = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    clear_stats();

    // DC, R=4: pulse after exactly 4 samples, then every 4 cycles, settling to 100
    for (int i = 0; i < 40; i++) cyc(100, 1'b1, 2);
    cyc(100, 1'b0, 2);
    repeat (3) cyc(100, 1'b0, 2);
    check("dc_first_latency", first_pulse - first_acc_edge, 4);
    check("dc_spacing", last_pulse - prev_pulse, 4);
    check("dc_value", dut_last, 100);

    // Asynchronous reset in the middle of a frame clears the outputs at once
    cyc(100, 1'b1, 2);
    cyc(100, 1'b1, 2);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("async_reset_out", longint'(bus.out), 0);
    check("async_reset_valid", longint'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    clear_stats();
    for (int i = 0; i < 30; i++) cyc(77, 1'b1, 3);
    repeat (3) cyc(77, 1'b0, 3);
    check("post_reset_latency", first_pulse - first_acc_edge, 8);

    // Gapped input, R=8: a pulse every 16 cycles
    reset_for(2);
    for (int i = 0; i < 200; i++) cyc(50, (i % 2) == 0, 3);
    repeat (3) cyc(50, 1'b0, 3);
    check("gap_spacing", last_pulse - prev_pulse, 16);
    check("gap_value", dut_last, 50);

    // Rate request changes mid-frame; the running frame keeps R=4
    reset_for(1);
    cyc(20, 1'b1, 2);
    cyc(20, 1'b1, 2);
    for (int i = 0; i < 40; i++) cyc(20, 1'b1, 3);
    repeat (3) cyc(20, 1'b0, 3);
    check("ratechg_first", first_pulse - first_acc_edge, 4);
    check("ratechg_spacing", last_pulse - prev_pulse, 8);

    // Full scale at the maximum rate, then an over-range request clamped to it
    reset_for(1);
    for (int i = 0; i < 160; i++) cyc(255, 1'b1, 4);
    repeat (3) cyc(255, 1'b0, 4);
    check("fullscale_value", dut_last, 255);
    for (int i = 0; i < 80; i++) cyc(255, 1'b1, 7);
    repeat (3) cyc(255, 1'b0, 7);
    check("clamp_spacing", last_pulse - prev_pulse, 16);
    check("clamp_value", dut_last, 255);

    // Alternating 1,0 at R=2: average 0.5 truncates to 0 or rounds to 1
    reset_for(1);
    for (int i = 0; i < 40; i++) cyc(((i % 2) == 0) ? 1 : 0, 1'b1, 1);
    repeat (3) cyc(0, 1'b0, 1);
    check("round_value", dut_last, ROUND_EXP);

    // rate_log2=0 behaves as R=2
    reset_for(1);
    for (int i = 0; i < 20; i++) cyc(9, 1'b1, 0);
    repeat (3) cyc(9, 1'b0, 0);
    check("rate0_spacing", last_pulse - prev_pulse, 2);

    // Random traffic with rate changes and occasional resets
    rl = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) rl = int'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) reset_for(int'($urandom_range(1, 2)));
      cyc(int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, rl);
    end
    repeat (4) cyc(0, 1'b0, rl);
    check("random_queue_drained", longint'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter WIDTH, default 8: input and output sample width, unsigned.
REQ-002 Parameter STAGES, default 3: number of integrator stages and number of comb stages, minimum 1.
REQ-003 Parameter MAX_RATE_LOG2, default 4: log2 of the largest supported decimation rate, minimum 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 in  input  WIDTH  input sample.
REQ-007 in_valid  input  1  qualifies in; one sample is accepted per cycle with in_valid=1.
REQ-008 rate_log2  input  $clog2(MAX_RATE_LOG2+1)  requested decimation rate R = 2^rate_log2.
REQ-009 out  output  WIDTH  decimated, normalised output sample.
REQ-010 out_valid  output  1  single-cycle pulse qualifying out.

Function
REQ-011 Internal register width SHALL be RW = WIDTH + STAGES*MAX_RATE_LOG2; in is zero-extended to RW.
REQ-012 All integrator and comb arithmetic SHALL be modulo 2^RW; wrap-around is intentional and is not flagged.
REQ-013 Integrators SHALL update only in cycles with in_valid=1: stage 0 adds in; stage k adds the pre-edge value of stage k-1.
REQ-014 With in_valid=0, integrators, the phase counter and the latched rate SHALL hold.
REQ-015 Phase counter counts accepted samples 0..R-1; the accepted sample at phase R-1 completes a frame, and the counter returns to 0.
REQ-016 Effective rate for a frame SHALL be rate_log2 sampled on that frame's first accepted sample (phase 0); changes mid-frame take effect at the next frame.
REQ-017 rate_log2=0 SHALL be treated as 1; values above MAX_RATE_LOG2 SHALL be clamped to MAX_RATE_LOG2.
REQ-018 Frame completion SHALL, one cycle later, advance all comb stages once: each comb outputs input minus its stored previous input (differential delay 1) and stores the current input; combs are chained combinationally.
REQ-019 Normalisation: last comb output shifted right by STAGES*effective_rate_log2, lower WIDTH bits taken.
REQ-020 out and out_valid SHALL be registered; out_valid=1 exactly 2 cycles after the in_valid cycle that completed the frame; out holds its value between pulses.
REQ-021 No internal derived clocks; all state SHALL run on clk with enables.
REQ-022 Constant input x SHALL produce out=x exactly after the first STAGES output pulses (gain R^STAGES is exact).

Reset
REQ-023 While rstn=0: out=0, out_valid=0, integrators, comb delay registers, phase counter, pending frame strobe all 0, latched rate = 1.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame and any pending out_valid; the first accepted sample after release starts phase 0.

Configuration
REQ-025 Macro CIC_DECIMATOR_ROUND_EN: when defined, normalisation SHALL add 2^(shift-1) before shifting (round half up) and saturate to 2^WIDTH-1.
REQ-026 When CIC_DECIMATOR_ROUND_EN is undefined, normalisation SHALL truncate with no saturation logic; timing is identical in both builds.

Verification
REQ-027 Reset: assert rstn=0 mid-frame with WIDTH=8, STAGES=3 -> out=0, out_valid=0 immediately; after release, first pulse follows exactly R accepted samples.
REQ-028 DC: in=100, in_valid=1 continuous, rate_log2=2 -> out_valid every 4 cycles; out=100 from the 4th pulse onward.
REQ-029 Gapped input: in=50, in_valid toggling 1/0, rate_log2=3 -> out_valid every 16 cycles, 2 cycles after the 8th accepted sample; out=50 in steady state.
REQ-030 Rate change: switch rate_log2 2->3 at phase 2 -> current frame completes after 4 samples; subsequent pulses spaced 8 accepted samples.
REQ-031 Full scale: in=255, rate_log2=4 (and rate_log2=7, clamped to 4) -> out=255 in steady state, no wrap-visible error.
REQ-032 Rounding (STAGES=1, rate_log2=1, in alternating 1,0) -> out=0 without CIC_DECIMATOR_ROUND_EN, out=1 with it.
